// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - requester and memory-port bundle for dmem_access_ctrl
//
// Purpose: groups both requester handshakes and the single data-memory port.
// Signals:
//   rN_req/we/size/signed/addr/wdata  requester N -> controller (N = 0 CPU LSU, 1 debug/DMA)
//   rN_ack/err/rdata                  controller -> requester N
//   mem_addr/mem_wdata/mem_we         controller -> memory (word index, write word, write enable)
//   mem_rdata                         memory -> controller, combinational read of mem_addr
// Modports: slave = controller side, master = requesters plus memory side.
interface dmem_access_ctrl_if #(
   parameter int DataWidth = 32
);
   logic                 r0_req;
   logic                 r0_we;
   logic [1:0]           r0_size;
   logic                 r0_signed;
   logic [DataWidth-1:0] r0_addr;
   logic [DataWidth-1:0] r0_wdata;
   logic                 r0_ack;
   logic                 r0_err;
   logic [DataWidth-1:0] r0_rdata;

   logic                 r1_req;
   logic                 r1_we;
   logic [1:0]           r1_size;
   logic                 r1_signed;
   logic [DataWidth-1:0] r1_addr;
   logic [DataWidth-1:0] r1_wdata;
   logic                 r1_ack;
   logic                 r1_err;
   logic [DataWidth-1:0] r1_rdata;

   logic [DataWidth-1:0] mem_addr;
   logic [DataWidth-1:0] mem_wdata;
   logic                 mem_we;
   logic [DataWidth-1:0] mem_rdata;

   modport slave (
      input  r0_req, r0_we, r0_size, r0_signed, r0_addr, r0_wdata,
      output r0_ack, r0_err, r0_rdata,
      input  r1_req, r1_we, r1_size, r1_signed, r1_addr, r1_wdata,
      output r1_ack, r1_err, r1_rdata,
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata
   );

   modport master (
      output r0_req, r0_we, r0_size, r0_signed, r0_addr, r0_wdata,
      input  r0_ack, r0_err, r0_rdata,
      output r1_req, r1_we, r1_size, r1_signed, r1_addr, r1_wdata,
      input  r1_ack, r1_err, r1_rdata,
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - two-requester arbiter and access controller for word-addressed data memory
//
// Purpose: shares one memory port between requester 0 and requester 1, one access in flight.
//   Converts byte addresses to word indices, extracts/extends loads, runs read-modify-write
//   for byte/halfword stores and rejects misaligned, illegal-size or out-of-range accesses.
// Ports:
//   clk  in  clock, all state on the rising edge
//   RST  in  synchronous active-high reset
//   bus  slave modport of dmem_access_ctrl_if (requester handshakes + memory port)
module dmem_access_ctrl #(
   parameter int DataWidth  = 32,
   parameter int Depth      = 100,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic               clk,
   input  logic               RST,
   dmem_access_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam logic [DataWidth-1:0] DepthW = DataWidth'(Depth);

   state_e               state_q, state_d;
   logic                 gnt_q, gnt_d;
   logic                 pref_q, pref_d;
   logic                 we_q, we_d;
   logic [1:0]           size_q, size_d;
   logic                 sgn_q, sgn_d;
   logic [DataWidth-1:0] addr_q, addr_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic                 err_q, err_d;
   logic [DataWidth-1:0] merged_q, merged_d;
   logic [DataWidth-1:0] rdata0_q, rdata0_d;
   logic [DataWidth-1:0] rdata1_q, rdata1_d;

   logic                 win;
   logic                 acc_err;
   logic [4:0]           sh;
   logic [DataWidth-1:0] lane;
   logic [DataWidth-1:0] lane_mask;
   logic [DataWidth-1:0] load_val;
   logic [DataWidth-1:0] merge_val;
   logic [DataWidth-1:0] word_idx;
   logic                 mem_we_raw;

   // When both request, the one not granted last wins unless requester 0 has fixed priority.
   always_comb begin
      win = 1'b0;
      if (bus.r0_req && bus.r1_req) begin
         win = FIXED_PRIO ? 1'b0 : pref_q;
      end else if (bus.r1_req) begin
         win = 1'b1;
      end
   end

   assign word_idx = {2'b00, addr_q[DataWidth-1:2]};
   assign acc_err  = (size_q == 2'b11)
                   || ((size_q == 2'b01) && addr_q[0])
                   || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
                   || (word_idx >= DepthW);

   // Little-endian lanes: byte lane k sits at bit 8k, so one shift serves loads and merges.
   assign sh   = {addr_q[1:0], 3'b000};
   assign lane = bus.mem_rdata >> sh;

   always_comb begin
      load_val  = bus.mem_rdata;
      lane_mask = 32'h0000_FFFF << sh;
      case (size_q)
         2'b00: begin
            load_val  = {{24{sgn_q & lane[7]}}, lane[7:0]};
            lane_mask = 32'h0000_00FF << sh;
         end
         2'b01: load_val = {{16{sgn_q & lane[15]}}, lane[15:0]};
         default: ;
      endcase
      merge_val = (bus.mem_rdata & ~lane_mask) | ((wdata_q << sh) & lane_mask);
   end

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      pref_d     = pref_q;
      we_d       = we_q;
      size_d     = size_q;
      sgn_d      = sgn_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      merged_d   = merged_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      mem_we_raw = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state_q)
         IDLE: begin
            if (bus.r0_req || bus.r1_req) begin
               gnt_d   = win;
               err_d   = 1'b0;
               we_d    = win ? bus.r1_we     : bus.r0_we;
               size_d  = win ? bus.r1_size   : bus.r0_size;
               sgn_d   = win ? bus.r1_signed : bus.r0_signed;
               addr_d  = win ? bus.r1_addr   : bus.r0_addr;
               wdata_d = win ? bus.r1_wdata  : bus.r0_wdata;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            bus.mem_addr = word_idx;
            state_d      = DONE;
            if (acc_err) begin
               err_d = 1'b1;
            end else if (!we_q) begin
               if (gnt_q) rdata1_d = load_val;
               else       rdata0_d = load_val;
            end else if (size_q == 2'b10) begin
               mem_we_raw    = 1'b1;
               bus.mem_wdata = wdata_q;
            end else begin
               // Sub-word store: the read half of the RMW happens now, the write next cycle.
               merged_d = merge_val;
               state_d  = WRITE;
            end
         end
         WRITE: begin
            bus.mem_addr  = word_idx;
            bus.mem_wdata = merged_q;
            mem_we_raw    = 1'b1;
            state_d       = DONE;
         end
         DONE: begin
            pref_d  = ~gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset must block a write even in the middle of an RMW, so gate combinationally.
   assign bus.mem_we   = mem_we_raw & ~RST;
   assign bus.r0_ack   = (state_q == DONE) && !gnt_q;
   assign bus.r1_ack   = (state_q == DONE) &&  gnt_q;
   assign bus.r0_err   = bus.r0_ack && err_q;
   assign bus.r1_err   = bus.r1_ack && err_q;
   assign bus.r0_rdata = rdata0_q;
   assign bus.r1_rdata = rdata1_q;

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         pref_q   <= 1'b0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         sgn_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         merged_q <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         pref_q   <= pref_d;
         we_q     <= we_d;
         size_q   <= size_d;
         sgn_q    <= sgn_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         merged_q <= merged_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

endmodule
